forward_metric_unit: RTL and testbench
======================================

// Module: forward_metric_unit
// PURPOSE
// Forward (alpha) state-metric recursion for the max-log-MAP SISO decoder. 8-state LTE RSC trellis.
// Sits directly downstream of the branch-metric stage and consumes its init_branch1/init_branch2/valid_out stream.
// Emits, per trellis step k, alpha_k together with the step's branch metrics, feeding the LLR/extrinsic stage.
// PARAMETERS
// BM_W    16     branch-metric width (signed)
// SM_W    18     state-metric width (signed)
// MAX_BLK 6144   largest supported block length
// PORTS
// clk        in   1        clock
// rst        in   1        synchronous, active-high reset
// branch1    in   BM_W     signed b1 for step k
// branch2    in   BM_W     signed b2 for step k
// valid_in   in   1        branch pair valid; gaps allowed, no backpressure
// blklen     in   13       block length K; sampled on first valid_in of a block
// alpha_o    out  8*SM_W   alpha_k, state s at [s*SM_W +: SM_W]
// branch1_o  out  BM_W     branch1 delayed to align with alpha_o
// branch2_o  out  BM_W     branch2 delayed to align with alpha_o
// valid_out  out  1        alpha_o/branch*_o valid
// first_o    out  1        marks step 0
// last_o     out  1        marks step K-1
// BEHAVIOUR
// - One clock; reset is synchronous and active-high (clk, rst).
// - Reset: all outputs 0; alpha register = {0, MINUS_INF x7}; step counter 0; state IDLE.
// - Trellis: state s = {s1,s2,s3} (s1 MSB). Input u: a=u^s2^s3; p=a^s1^s3; next={a,s1,s2}.
// - Gamma(u,p): (0,0)=+b1, (1,1)=-b1, (0,1)=+b2, (1,0)=-b2. Each state has exactly 2 predecessors.
// - ACS: alpha_{k+1}[s'] = max over the 2 predecessors of (alpha_k[s] + gamma). Add is done at SM_W+1 bits.
// - Normalise: subtract the new alpha[0] from all 8 metrics, then saturate to [MINUS_INF, 2^(SM_W-1)-1].
//   MINUS_INF = -2^(SM_W-2). alpha[0] is therefore always 0 after a step.
// - FSM IDLE->RUN on valid_in: latch blklen, load alpha_0 = init, process step 0.
//   RUN: each valid_in is one step, counter k++. On the valid_in with k==K-1, return to IDLE; alpha re-inits.
// - Latency 1 cycle: the cycle after valid_in at step k, valid_out=1 with alpha_o=alpha_k (pre-update metrics)
//   and the step-k branches. first_o=(k==0), last_o=(k==K-1). Outputs hold when valid_out=0.
// - valid_in gaps: no state change; valid_out=0.
// - blklen changes mid-block are ignored until the next block.
// - K=1: first_o and last_o both 1 on the same output.
// - rst mid-block: immediate return to reset values, partial block discarded, next valid_in is step 0.
// - blklen=0 or >MAX_BLK: treated as MAX_BLK.
// STRUCTURE
// - siso_pkg: NUM_STATES=8, trellis next_state/parity functions, predecessor table, MINUS_INF/SM_W constants,
//   alpha_vec_t typedef.
// - Sub-module acs_unit (x8): two adds, compare, select. Normalise/saturate stays in the top level.
// TESTING
// - Step 0, b1=10, b2=4 -> out: alpha_0={0,-inf..}, first_o=1. Next alpha: [0]=0, [4]=-20, others MINUS_INF.
// - K=4 stream, b1=b2=0 -> 4 valid_out with first_o on the 1st and last_o on the 4th.
//   After 3 steps all reachable states are 0.
// - Back-to-back blocks (K=40, then K=512, no gap) -> the second block's first output is alpha_0 init,
//   last_o at output 512.
// - Random gaps in valid_in over K=512 -> alpha_o sequence matches the gapless run and the model file.
// - b1=b2=+32767 for 64 steps -> no wrap; all metrics stay within [MINUS_INF, max]; alpha_o[0]==0 always.
// - rst pulsed at step 100 of K=512 -> outputs 0 next cycle; the following valid_in gives first_o=1 and alpha_0 init.

Source files
------------

// File: rtl/siso_pkg.sv
// Shared trellis definitions for the max-log-MAP SISO datapath (8-state LTE RSC code).
package siso_pkg;

  localparam int NUM_STATES = 8;
  localparam int BM_W       = 16;
  localparam int SM_W       = 18;
  localparam int MAX_BLK    = 6144;
  localparam int BLK_W      = 13;

  localparam logic signed [SM_W-1:0] MINUS_INF = SM_W'(-(2 ** (SM_W - 2)));
  localparam logic signed [SM_W-1:0] SM_MAX    = SM_W'((2 ** (SM_W - 1)) - 1);

  typedef logic [NUM_STATES-1:0][SM_W-1:0] alpha_vec_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } fmu_state_t;

  // State s = {s1,s2,s3}; a = u^s2^s3, next = {a,s1,s2}.
  function automatic logic [2:0] next_state(input logic [2:0] s, input logic u);
    logic a;
    a = u ^ s[1] ^ s[0];
    return {a, s[2], s[1]};
  endfunction

  function automatic logic parity(input logic [2:0] s, input logic u);
    logic a;
    a = u ^ s[1] ^ s[0];
    return a ^ s[2] ^ s[0];
  endfunction

  // Predecessor j of state sn is {sn[1], sn[0], j}; its input bit follows from a = sn[2].
  function automatic logic [2:0] pred_state(input logic [2:0] sn, input logic j);
    return {sn[1], sn[0], j};
  endfunction

  function automatic logic pred_input(input logic [2:0] sn, input logic j);
    return sn[2] ^ sn[0] ^ j;
  endfunction

  function automatic alpha_vec_t alpha_init();
    alpha_vec_t v;
    for (int s = 0; s < NUM_STATES; s++) begin
      v[s] = (s == 0) ? '0 : MINUS_INF;
    end
    return v;
  endfunction

  function automatic logic [BLK_W-1:0] blk_norm(input logic [BLK_W-1:0] b);
    if (b == '0 || b > BLK_W'(MAX_BLK)) return BLK_W'(MAX_BLK);
    return b;
  endfunction

  // One extra bit so that negating -2^(BM_W-1) cannot wrap.
  function automatic logic signed [BM_W:0] gamma_sel(input logic u, input logic p,
                                                      input logic signed [BM_W-1:0] b1,
                                                      input logic signed [BM_W-1:0] b2);
    logic signed [BM_W:0] e1;
    logic signed [BM_W:0] e2;
    e1 = {b1[BM_W-1], b1};
    e2 = {b2[BM_W-1], b2};
    case ({u, p})
      2'b00:   return e1;
      2'b11:   return -e1;
      2'b01:   return e2;
      default: return -e2;
    endcase
  endfunction

endpackage

// File: rtl/acs_unit.sv
// Add-compare-select for one trellis state: best of two predecessor metrics plus branch gamma.
module acs_unit
  import siso_pkg::*;
(
  input  logic signed [SM_W-1:0] alpha_a,
  input  logic signed [SM_W-1:0] alpha_b,
  input  logic signed [BM_W:0]   gamma_a,
  input  logic signed [BM_W:0]   gamma_b,
  output logic signed [SM_W:0]   metric
);

  logic signed [SM_W:0] sum_a;
  logic signed [SM_W:0] sum_b;

  always_comb begin
    sum_a  = {alpha_a[SM_W-1], alpha_a} + {{(SM_W - BM_W){gamma_a[BM_W]}}, gamma_a};
    sum_b  = {alpha_b[SM_W-1], alpha_b} + {{(SM_W - BM_W){gamma_b[BM_W]}}, gamma_b};
    metric = (sum_a >= sum_b) ? sum_a : sum_b;
  end

endmodule

// File: rtl/forward_metric_unit.sv
// Forward (alpha) recursion: one trellis step per valid branch pair, alpha_k emitted one cycle later.
// state   | meaning
// ST_IDLE | between blocks; alpha holds init, next valid_in is step 0 and samples blklen
// ST_RUN  | inside a block; each valid_in advances k until k == K-1
module forward_metric_unit
  import siso_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [BM_W-1:0]       branch1,
  input  logic signed [BM_W-1:0]       branch2,
  input  logic                         valid_in,
  input  logic [BLK_W-1:0]             blklen,
  output logic [NUM_STATES*SM_W-1:0]   alpha_o,
  output logic signed [BM_W-1:0]       branch1_o,
  output logic signed [BM_W-1:0]       branch2_o,
  output logic                         valid_out,
  output logic                         first_o,
  output logic                         last_o
);

  localparam logic signed [SM_W+1:0] DIFF_MIN = {{2{MINUS_INF[SM_W-1]}}, MINUS_INF};
  localparam logic signed [SM_W+1:0] DIFF_MAX = {{2{SM_MAX[SM_W-1]}}, SM_MAX};

  fmu_state_t           state_q;
  logic [BLK_W-1:0]     k_q;
  logic [BLK_W-1:0]     blk_q;
  logic [BLK_W-1:0]     blk_eff;
  logic                 is_last;
  alpha_vec_t           alpha_q;
  alpha_vec_t           alpha_nxt;
  logic signed [SM_W:0]   acs_m [NUM_STATES];
  logic signed [SM_W+1:0] diff  [NUM_STATES];

  for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
    localparam logic [2:0] PA = pred_state(3'(s), 1'b0);
    localparam logic [2:0] PB = pred_state(3'(s), 1'b1);
    localparam logic       UA = pred_input(3'(s), 1'b0);
    localparam logic       UB = pred_input(3'(s), 1'b1);
    localparam logic       XA = parity(PA, UA);
    localparam logic       XB = parity(PB, UB);

    acs_unit u_acs (
      .alpha_a (alpha_q[PA]),
      .alpha_b (alpha_q[PB]),
      .gamma_a (gamma_sel(UA, XA, branch1, branch2)),
      .gamma_b (gamma_sel(UB, XB, branch1, branch2)),
      .metric  (acs_m[s])
    );
  end

  // Re-reference to state 0 so alpha[0] stays 0, then clamp to the metric range.
  always_comb begin
    alpha_nxt = '0;
    for (int s = 0; s < NUM_STATES; s++) begin
      diff[s] = {acs_m[s][SM_W], acs_m[s]} - {acs_m[0][SM_W], acs_m[0]};
      if (diff[s] < DIFF_MIN)      alpha_nxt[s] = MINUS_INF;
      else if (diff[s] > DIFF_MAX) alpha_nxt[s] = SM_MAX;
      else                         alpha_nxt[s] = diff[s][SM_W-1:0];
    end
  end

  always_comb begin
    blk_eff = (state_q == ST_IDLE) ? blk_norm(blklen) : blk_q;
    is_last = (k_q == blk_eff - BLK_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      blk_q     <= '0;
      alpha_q   <= alpha_init();
      alpha_o   <= '0;
      branch1_o <= '0;
      branch2_o <= '0;
      valid_out <= 1'b0;
      first_o   <= 1'b0;
      last_o    <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        alpha_o   <= alpha_q;
        branch1_o <= branch1;
        branch2_o <= branch2;
        first_o   <= (k_q == '0);
        last_o    <= is_last;
        blk_q     <= blk_eff;
        if (is_last) begin
          state_q <= ST_IDLE;
          k_q     <= '0;
          alpha_q <= alpha_init();
        end else begin
          state_q <= ST_RUN;
          k_q     <= k_q + BLK_W'(1);
          alpha_q <= alpha_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_forward_metric_unit.sv
// Randomized bench for forward_metric_unit against a forward-iterating max-log trellis model.
module tb_forward_metric_unit;

  localparam int NS   = 8;
  localparam int SW   = 18;
  localparam int BW   = 16;
  localparam int MAXK = 6144;
  localparam int MINF = -(1 << (SW - 2));
  localparam int SMAX = (1 << (SW - 1)) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [BW-1:0]      branch1, branch2;
  logic               valid_in;
  logic [12:0]        blklen;
  logic [NS*SW-1:0]   alpha_o;
  logic [BW-1:0]      branch1_o, branch2_o;
  logic               valid_out, first_o, last_o;

  forward_metric_unit dut (
    .clk       (clk),
    .rst       (rst),
    .branch1   (branch1),
    .branch2   (branch2),
    .valid_in  (valid_in),
    .blklen    (blklen),
    .alpha_o   (alpha_o),
    .branch1_o (branch1_o),
    .branch2_o (branch2_o),
    .valid_out (valid_out),
    .first_o   (first_o),
    .last_o    (last_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int  m_alpha [NS];
  int  m_k, m_K;
  bit  m_run;

  logic [NS*SW-1:0] e_alpha;
  logic [BW-1:0]    e_b1, e_b2;
  logic             e_first, e_last;

  int               br1 [MAXK];
  int               br2 [MAXK];
  logic [NS*SW-1:0] rec [MAXK];

  task automatic check_eq(input string tag, input logic [NS*SW-1:0] got, input logic [NS*SW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  function automatic int norm_k(input int b);
    return (b == 0 || b > MAXK) ? MAXK : b;
  endfunction

  function automatic logic [NS*SW-1:0] pack_alpha();
    logic [NS*SW-1:0] v;
    v = '0;
    for (int s = 0; s < NS; s++) v[s*SW +: SW] = SW'(m_alpha[s]);
    return v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) m_alpha[s] = (s == 0) ? 0 : MINF;
    m_k   = 0;
    m_run = 1'b0;
  endtask

  // Walk every (state, input) edge forward and keep the best arrival metric.
  task automatic model_advance(input int b1, input int b2);
    int nw [NS];
    for (int s = 0; s < NS; s++) nw[s] = -1000000000;
    for (int s = 0; s < NS; s++) begin
      for (int u = 0; u < 2; u++) begin
        int s1, s2, s3, a, p, ns, g, c;
        s1 = (s >> 2) & 1;
        s2 = (s >> 1) & 1;
        s3 = s & 1;
        a  = u ^ s2 ^ s3;
        p  = a ^ s1 ^ s3;
        ns = a * 4 + s1 * 2 + s2;
        if (u == 0 && p == 0)      g = b1;
        else if (u == 1 && p == 1) g = -b1;
        else if (u == 0)           g = b2;
        else                       g = -b2;
        c = m_alpha[s] + g;
        if (c > nw[ns]) nw[ns] = c;
      end
    end
    for (int s = 0; s < NS; s++) begin
      int d;
      d = nw[s] - nw[0];
      if (d < MINF) d = MINF;
      if (d > SMAX) d = SMAX;
      m_alpha[s] = d;
    end
  endtask

  task automatic check_outputs(input logic exp_valid);
    check_eq("valid_out", valid_out, exp_valid);
    check_eq("alpha_o", alpha_o, e_alpha);
    check_eq("branch1_o", branch1_o, e_b1);
    check_eq("branch2_o", branch2_o, e_b2);
    check_eq("first_o", first_o, e_first);
    check_eq("last_o", last_o, e_last);
  endtask

  task automatic step(input bit vin, input int b1, input int b2, input int blk);
    @(negedge clk);
    valid_in = vin;
    branch1  = BW'(b1);
    branch2  = BW'(b2);
    blklen   = 13'(blk);
    @(posedge clk);
    #1;
    if (vin) begin
      if (!m_run) begin
        m_K   = norm_k(blk);
        m_k   = 0;
        m_run = 1'b1;
      end
      e_alpha = pack_alpha();
      e_b1    = BW'(b1);
      e_b2    = BW'(b2);
      e_first = (m_k == 0);
      e_last  = (m_k == m_K - 1);
      model_advance(b1, b2);
      if (e_last) model_reset();
      else m_k++;
    end
    check_outputs(vin);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    e_alpha = '0;
    e_b1    = '0;
    e_b2    = '0;
    e_first = 1'b0;
    e_last  = 1'b0;
    check_outputs(1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      br1[i] = rnd16();
      br2[i] = rnd16();
    end
  endtask

  task automatic fill_const(input int n, input int v1, input int v2);
    for (int i = 0; i < n; i++) begin
      br1[i] = v1;
      br2[i] = v2;
    end
  endtask

  // mode 1 records alpha_o per step, mode 2 compares against the recording.
  task automatic run_block(input int nsteps, input int blk_in, input int gap_pct,
                           input int mode, input bit range_chk);
    int n;
    n = 0;
    while (n < nsteps) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        step(1'b0, rnd16(), rnd16(), int'($urandom_range(8191)));
      end else begin
        step(1'b1, br1[n], br2[n], (n == 0) ? blk_in : int'($urandom_range(8191)));
        if (mode == 1) rec[n] = alpha_o;
        if (mode == 2) check_eq("gap_vs_gapless", alpha_o, rec[n]);
        if (range_chk) begin
          for (int s = 0; s < NS; s++) begin
            logic signed [SW-1:0] v;
            int iv;
            v  = alpha_o[s*SW +: SW];
            iv = int'(v);
            check_eq("sat_range", (iv >= MINF && iv <= SMAX), 1'b1);
          end
          check_eq("sat_alpha0", alpha_o[SW-1:0], '0);
        end
        n++;
      end
    end
  endtask

  initial begin
    logic [NS*SW-1:0] exp_v;
    rst      = 1'b1;
    valid_in = 1'b0;
    branch1  = '0;
    branch2  = '0;
    blklen   = '0;
    model_reset();
    do_reset();

    // Step 0 with b1=10, b2=4, then inspect alpha_1.
    step(1'b1, 10, 4, 2);
    check_eq("step0_first", first_o, 1'b1);
    step(1'b1, 0, 0, 2);
    exp_v = '0;
    for (int s = 0; s < NS; s++) exp_v[s*SW +: SW] = SW'((s == 0) ? 0 : (s == 4) ? -20 : MINF);
    check_eq("step1_alpha", alpha_o, exp_v);
    check_eq("step1_last", last_o, 1'b1);

    // K=1: first and last together.
    step(1'b1, rnd16(), rnd16(), 1);
    check_eq("k1_first", first_o, 1'b1);
    check_eq("k1_last", last_o, 1'b1);

    // K=4 all-zero branches: every state reachable and tied after three steps.
    fill_const(4, 0, 0);
    run_block(4, 4, 0, 0, 1'b0);
    check_eq("k4_alpha3_zero", alpha_o, '0);
    check_eq("k4_last", last_o, 1'b1);

    // Back-to-back blocks with no idle cycle between them.
    fill_rand(40);
    run_block(40, 40, 0, 0, 1'b0);
    fill_rand(512);
    run_block(512, 512, 0, 0, 1'b0);
    check_eq("b2b_last", last_o, 1'b1);

    // Same branch stream with and without valid_in gaps.
    fill_rand(512);
    run_block(512, 512, 0, 1, 1'b0);
    run_block(512, 512, 30, 2, 1'b0);

    // Extreme branch metrics must clamp, never wrap.
    fill_const(64, 32767, 32767);
    run_block(64, 64, 0, 0, 1'b1);
    fill_const(64, -32768, 32767);
    run_block(64, 64, 0, 0, 1'b1);

    // Reset in the middle of a block.
    fill_rand(512);
    run_block(100, 512, 0, 0, 1'b0);
    do_reset();
    fill_rand(3);
    run_block(3, 3, 0, 0, 1'b0);

    // Out-of-range block lengths fall back to the maximum.
    fill_rand(MAXK);
    run_block(MAXK, 0, 10, 0, 1'b0);
    run_block(MAXK, 7000, 0, 0, 1'b0);
    check_eq("maxblk_last", last_o, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
